// File: rtl/regfile_write_arbiter.sv
// Sole owner of the register-file write port: merges pipeline writebacks with buffered
// long-latency results and tracks which registers still await a long-latency result.
module regfile_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wr,
  input  logic [4:0]      pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_waddr,
  input  logic [XLEN-1:0] lu_wdata,
  input  logic            iss_valid,
  input  logic [4:0]      iss_waddr,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            chk_hazard,
  output logic            reg_wrW,
  output logic [4:0]      waddrW,
  output logic [XLEN-1:0] wdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      fifo_addr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          push, pop, fifo_empty;
  logic [4:0]    head_addr;
  logic [XLEN-1:0] head_data;
  logic [NREG-1:0] busy;
  logic          iss_set;

  assign fifo_empty = (count_reg == CW'(0));
  assign lu_ready   = (count_reg != CW'(FIFO_DEPTH));
  assign push       = lu_valid && lu_ready;
  // The pipeline never waits, so the FIFO only drains on cycles it leaves free.
  assign pop        = !pipe_wr && !fifo_empty;
  assign head_addr  = fifo_addr[rd_ptr_reg];
  assign head_data  = fifo_data[rd_ptr_reg];
  assign iss_set    = iss_valid && (iss_waddr != 5'd0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= lu_waddr;
      fifo_data[wr_ptr_reg] <= lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Scoreboard: a new issue to the same register outranks the retiring result.
  assign busy[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      always_ff @(posedge clk) begin
        if (!rst) begin
          busy[gi] <= 1'b0;
        end else if (iss_set && (iss_waddr == 5'(gi))) begin
          busy[gi] <= 1'b1;
        end else if (pop && (head_addr == 5'(gi))) begin
          busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign chk_hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_wrW <= 1'b0;
      waddrW  <= 5'd0;
      wdata   <= '0;
    end else if (pipe_wr) begin
      reg_wrW <= (pipe_waddr != 5'd0);
      waddrW  <= pipe_waddr;
      wdata   <= pipe_wdata;
    end else if (pop) begin
      reg_wrW <= (head_addr != 5'd0);
      waddrW  <= head_addr;
      wdata   <= head_data;
    end else begin
      reg_wrW <= 1'b0;
    end
  end

endmodule
